// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM-engine arbiter: byte-count encodings,
// FSM state encoding and the memory-mapped I/O address window.
// No logic; constants, types and one address-decode helper only.
package mem_arbiter_pkg;

    // Engine byte-count encodings (one-hot, LSB-aligned transfers)
    localparam logic [2:0] WIDTH_BYTE = 3'b001;
    localparam logic [2:0] WIDTH_HALF = 3'b010;
    localparam logic [2:0] WIDTH_WORD = 3'b100;

    // addr[17:16] value that selects the memory-mapped I/O region
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Default number of back-to-back data grants tolerated while a fetch waits
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

    function automatic logic is_io_addr(input logic [31:0] addr, input logic [1:0] hi);
        return (addr[17:16] == hi);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Purpose : single-outstanding request/grant arbiter between the data port,
//           the fetch port and the byte-serial RAM engine.
// Latency : req in IDLE at N -> gnt + eng_req at N+1; eng_done at M -> done at M+1.
// Backpr. : requesters hold req until gnt; req is ignored while a transaction
//           is in flight; the engine handshake is level req / pulse done.
//
// Ports
//   clk_in, rst_in (async, active-high)
//   jump_or_not_in         branch flush, squashes fetch results
//   io_buffer_full_in      UART buffer full (used only with MEM_ARB_IO_STALL_EN)
//   d_*                    data port: req/wr/width/addr/wdata in, gnt/done/rdata out
//   i_*                    fetch port: req/addr in, gnt/done/rdata out
//   eng_*                  engine: req/wr/width/addr/wdata out, done/rdata in
//
// Build option
//   MEM_ARB_IO_STALL_EN : when defined, data writes into the I/O window are held
//                         off while io_buffer_full_in is high; otherwise that
//                         input is ignored.
module mem_arbiter #(
    parameter int         STARVE_LIMIT = mem_arbiter_pkg::STARVE_LIMIT_DEF,
    parameter logic [1:0] IO_ADDR_HI   = mem_arbiter_pkg::IO_ADDR_HI
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        jump_or_not_in,
    input  logic        io_buffer_full_in,
    input  logic        d_req_in,
    input  logic        d_wr_in,
    input  logic [2:0]  d_width_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    output logic        d_gnt_out,
    output logic        d_done_out,
    output logic [31:0] d_rdata_out,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_gnt_out,
    output logic        i_done_out,
    output logic [31:0] i_rdata_out,
    output logic        eng_req_out,
    output logic        eng_wr_out,
    output logic [2:0]  eng_width_out,
    output logic [31:0] eng_addr_out,
    output logic [31:0] eng_wdata_out,
    input  logic        eng_done_in,
    input  logic [31:0] eng_rdata_in
);
    import mem_arbiter_pkg::*;

    localparam int             CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             squash_q, squash_d;

    logic        d_gnt_d, d_done_d, i_gnt_d, i_done_d;
    logic [31:0] d_rdata_d, i_rdata_d;
    logic        eng_req_d, eng_wr_d;
    logic [2:0]  eng_width_d;
    logic [31:0] eng_addr_d, eng_wdata_d;

    logic d_elig, i_elig, pick_d, pick_i, fetch_killed;

    // Data eligibility: optionally hold off I/O writes while the UART is full.
`ifdef MEM_ARB_IO_STALL_EN
    assign d_elig = d_req_in &&
                    !(d_wr_in && is_io_addr(d_addr_in, IO_ADDR_HI) && io_buffer_full_in);
`else
    logic unused_io;
    assign unused_io = io_buffer_full_in ^ (^IO_ADDR_HI);
    assign d_elig    = d_req_in;
`endif

    assign i_elig = i_req_in && !jump_or_not_in;

    // Data has priority until the starvation budget is spent; at the limit a
    // waiting fetch takes the slot, but data still goes if no fetch can.
    assign pick_d = d_elig && ((starve_q < LIMIT) || !i_elig);
    assign pick_i = !pick_d && i_elig;

    // A flush arriving together with the engine's done still kills the result.
    assign fetch_killed = squash_q || jump_or_not_in;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        squash_d    = squash_q;
        d_gnt_d     = 1'b0;
        d_done_d    = 1'b0;
        i_gnt_d     = 1'b0;
        i_done_d    = 1'b0;
        d_rdata_d   = d_rdata_out;
        i_rdata_d   = i_rdata_out;
        eng_req_d   = eng_req_out;
        eng_wr_d    = eng_wr_out;
        eng_width_d = eng_width_out;
        eng_addr_d  = eng_addr_out;
        eng_wdata_d = eng_wdata_out;

        case (state_q)
            ST_IDLE: begin
                if (!i_req_in) begin
                    starve_d = '0;
                end
                if (pick_d) begin
                    d_gnt_d     = 1'b1;
                    eng_req_d   = 1'b1;
                    eng_wr_d    = d_wr_in;
                    eng_width_d = d_width_in;
                    eng_addr_d  = d_addr_in;
                    eng_wdata_d = d_wdata_in;
                    state_d     = ST_BUSY_D;
                    if (i_req_in && (starve_q != LIMIT)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (pick_i) begin
                    i_gnt_d     = 1'b1;
                    eng_req_d   = 1'b1;
                    eng_wr_d    = 1'b0;
                    eng_width_d = WIDTH_WORD;
                    eng_addr_d  = i_addr_in;
                    eng_wdata_d = '0;
                    starve_d    = '0;
                    squash_d    = 1'b0;
                    state_d     = ST_BUSY_I;
                end
            end

            ST_BUSY_D: begin
                if (eng_done_in) begin
                    eng_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    d_rdata_d = eng_rdata_in;
                    // Writes take one dead cycle for RAM write-to-read turnaround.
                    state_d   = eng_wr_out ? ST_GAP : ST_IDLE;
                end
            end

            ST_BUSY_I: begin
                if (jump_or_not_in) begin
                    squash_d = 1'b1;
                end
                if (eng_done_in) begin
                    eng_req_d = 1'b0;
                    if (!fetch_killed) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = eng_rdata_in;
                    end
                    squash_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            starve_q      <= '0;
            squash_q      <= 1'b0;
            d_gnt_out     <= 1'b0;
            d_done_out    <= 1'b0;
            d_rdata_out   <= '0;
            i_gnt_out     <= 1'b0;
            i_done_out    <= 1'b0;
            i_rdata_out   <= '0;
            eng_req_out   <= 1'b0;
            eng_wr_out    <= 1'b0;
            eng_width_out <= '0;
            eng_addr_out  <= '0;
            eng_wdata_out <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            squash_q      <= squash_d;
            d_gnt_out     <= d_gnt_d;
            d_done_out    <= d_done_d;
            d_rdata_out   <= d_rdata_d;
            i_gnt_out     <= i_gnt_d;
            i_done_out    <= i_done_d;
            i_rdata_out   <= i_rdata_d;
            eng_req_out   <= eng_req_d;
            eng_wr_out    <= eng_wr_d;
            eng_width_out <= eng_width_d;
            eng_addr_out  <= eng_addr_d;
            eng_wdata_out <= eng_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM engine, scoreboard of expected
// completions (pushed at grant, popped at done), directed scenarios.
module tb_mem_arbiter;

    logic        clk_in, rst_in;
    logic        jump_or_not_in, io_buffer_full_in;
    logic        d_req_in, d_wr_in;
    logic [2:0]  d_width_in;
    logic [31:0] d_addr_in, d_wdata_in;
    logic        d_gnt_out, d_done_out;
    logic [31:0] d_rdata_out;
    logic        i_req_in;
    logic [31:0] i_addr_in;
    logic        i_gnt_out, i_done_out;
    logic [31:0] i_rdata_out;
    logic        eng_req_out, eng_wr_out;
    logic [2:0]  eng_width_out;
    logic [31:0] eng_addr_out, eng_wdata_out;
    logic        eng_done_in;
    logic [31:0] eng_rdata_in;

    mem_arbiter #(.STARVE_LIMIT(8), .IO_ADDR_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .jump_or_not_in(jump_or_not_in), .io_buffer_full_in(io_buffer_full_in),
        .d_req_in(d_req_in), .d_wr_in(d_wr_in), .d_width_in(d_width_in),
        .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in),
        .d_gnt_out(d_gnt_out), .d_done_out(d_done_out), .d_rdata_out(d_rdata_out),
        .i_req_in(i_req_in), .i_addr_in(i_addr_in),
        .i_gnt_out(i_gnt_out), .i_done_out(i_done_out), .i_rdata_out(i_rdata_out),
        .eng_req_out(eng_req_out), .eng_wr_out(eng_wr_out), .eng_width_out(eng_width_out),
        .eng_addr_out(eng_addr_out), .eng_wdata_out(eng_wdata_out),
        .eng_done_in(eng_done_in), .eng_rdata_in(eng_rdata_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Engine read data is a fixed function of address
    function automatic logic [31:0] eng_data(input logic [31:0] addr);
        if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    typedef struct {
        logic        is_i;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic gnt_log[$];   // 0 = data grant, 1 = fetch grant

    // ---------------- behavioural engine ----------------
    int          eng_lat = 3;
    int          eng_cnt;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wr;
    logic [2:0]  cap_width;

    initial begin
        eng_done_in  = 1'b0;
        eng_rdata_in = '0;
        eng_cnt      = 0;
        forever begin
            @(posedge clk_in);
            #2;
            if (eng_done_in) begin
                eng_done_in = 1'b0;
                eng_cnt     = 0;
            end else if (eng_req_out) begin
                if (eng_cnt == 0) begin
                    cap_addr  = eng_addr_out;
                    cap_wdata = eng_wdata_out;
                    cap_wr    = eng_wr_out;
                    cap_width = eng_width_out;
                end else begin
                    chk("eng_stable", {eng_wr_out, eng_width_out, eng_addr_out, eng_wdata_out},
                        {cap_wr, cap_width, cap_addr, cap_wdata});
                end
                eng_cnt++;
                if (eng_cnt >= eng_lat) begin
                    eng_done_in  = 1'b1;
                    eng_rdata_in = eng_data(eng_addr_out);
                end
            end else begin
                eng_cnt = 0;
            end
        end
    end

    // ---------------- grant / completion monitor ----------------
    always @(posedge clk_in) begin
        #1;
        if (!rst_in) begin
            if (d_gnt_out || i_gnt_out)
                chk("one_gnt", {63'd0, d_gnt_out & i_gnt_out}, 64'd0);
            if (d_gnt_out) begin
                gnt_log.push_back(1'b0);
                exp_q.push_back('{is_i: 1'b0, data: eng_data(d_addr_in)});
            end
            if (i_gnt_out) begin
                gnt_log.push_back(1'b1);
                exp_q.push_back('{is_i: 1'b1, data: eng_data(i_addr_in)});
            end
            if (d_done_out || i_done_out) begin
                chk("sb_pending", {63'd0, exp_q.size() > 0}, 64'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_port", {63'd0, i_done_out}, {63'd0, e.is_i});
                    chk("sb_data", {32'd0, (i_done_out ? i_rdata_out : d_rdata_out)}, {32'd0, e.data});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic drop_on_gnt = 1'b1;

    task automatic tick();
        @(negedge clk_in);
        if (drop_on_gnt && d_gnt_out) d_req_in = 1'b0;
        if (drop_on_gnt && i_gnt_out) i_req_in = 1'b0;
    endtask

    task automatic wait_eng_done(input int budget);
        int n = 0;
        while (!eng_done_in && n < budget) begin
            tick();
            n++;
        end
        chk("eng_done_seen", {63'd0, eng_done_in}, 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || eng_req_out || d_req_in || i_req_in) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", {63'd0, n < budget}, 64'd1);
        repeat (3) tick();
    endtask

    task automatic set_d(input logic wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] wd);
        d_req_in   = 1'b1;
        d_wr_in    = wr;
        d_width_in = w;
        d_addr_in  = a;
        d_wdata_in = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        rst_in = 1'b1;
        jump_or_not_in = 1'b0; io_buffer_full_in = 1'b0;
        d_req_in = 1'b0; d_wr_in = 1'b0; d_width_in = '0; d_addr_in = '0; d_wdata_in = '0;
        i_req_in = 1'b0; i_addr_in = '0;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("reset_ctl", {55'd0, d_gnt_out, d_done_out, i_gnt_out, i_done_out, eng_req_out,
                          eng_wr_out, eng_width_out}, 64'd0);
        chk("reset_rdata", {d_rdata_out, i_rdata_out}, 64'd0);
        chk("reset_eng", {eng_addr_out, eng_wdata_out}, 64'd0);
        rst_in = 1'b0;
        tick();

        // 1: basic read, width 4 at 0x100
        set_d(1'b0, 3'b100, 32'h100, 32'h0);
        tick();
        chk("t1_gnt", {62'd0, d_gnt_out, eng_req_out}, 64'd3);
        chk("t1_eng", {28'd0, eng_wr_out, eng_width_out, eng_addr_out}, {28'd0, 1'b0, 3'b100, 32'h100});
        wait_eng_done(20);
        tick();
        chk("t1_done_lat", {63'd0, d_done_out}, 64'd1);
        chk("t1_rdata", {32'd0, d_rdata_out}, {32'd0, 32'hDEAD_BEEF});
        drain(50);

        // 2: both requests held continuously -> 8 data, 1 fetch, repeating
        drop_on_gnt = 1'b0;
        gnt_log.delete();
        set_d(1'b0, 3'b100, 32'h200, 32'h0);
        i_addr_in = 32'h400;
        i_req_in  = 1'b1;
        cnt = 0;
        while (gnt_log.size() < 18 && cnt < 400) begin
            tick();
            cnt++;
        end
        d_req_in = 1'b0;
        i_req_in = 1'b0;
        drop_on_gnt = 1'b1;
        chk("starve_count", gnt_log.size(), 64'd18);
        for (int k = 0; k < 18 && k < gnt_log.size(); k++)
            chk($sformatf("starve_order[%0d]", k), {63'd0, gnt_log[k]}, {63'd0, (k % 9) == 8});
        drain(100);

        // 3: flush while a fetch is in flight -> no i_done, next fetch normal
        i_addr_in = 32'h800;
        i_req_in  = 1'b1;
        tick();
        chk("fl_gnt", {63'd0, i_gnt_out}, 64'd1);
        chk("fl_eng", {60'd0, eng_wr_out, eng_width_out}, {60'd0, 1'b0, 3'b100});
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        jump_or_not_in = 1'b1;
        tick();
        jump_or_not_in = 1'b0;
        wait_eng_done(20);
        tick();
        chk("fl_no_done", {62'd0, i_done_out, eng_req_out}, 64'd0);
        i_addr_in = 32'h900;
        i_req_in  = 1'b1;
        tick();
        chk("fl_next_gnt", {63'd0, i_gnt_out}, 64'd1);
        drain(50);

        // 4: I/O write while UART buffer full, with a fetch pending
        set_d(1'b1, 3'b001, 32'h0003_0000, 32'h55);
        io_buffer_full_in = 1'b1;
        i_addr_in = 32'hA00;
        i_req_in  = 1'b1;
        tick();
`ifdef MEM_ARB_IO_STALL_EN
        chk("io_fetch_first", {62'd0, i_gnt_out, d_gnt_out}, 64'd2);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (d_gnt_out) cnt++;
        end
        chk("io_no_dgnt", cnt, 64'd0);
        io_buffer_full_in = 1'b0;
        tick();
        chk("io_release", {63'd0, d_gnt_out}, 64'd1);
`else
        chk("io_immediate", {62'd0, i_gnt_out, d_gnt_out}, 64'd1);
`endif
        io_buffer_full_in = 1'b0;
        drain(80);

        // 5: write then read -> GAP cycle before the read is granted
        set_d(1'b1, 3'b010, 32'h1000, 32'hBEEF);
        tick();
        chk("gap_wr_gnt", {63'd0, d_gnt_out}, 64'd1);
        set_d(1'b0, 3'b100, 32'h1004, 32'h0);
        wait_eng_done(20);
        tick();
        chk("gap_c1", {62'd0, d_done_out, eng_req_out}, 64'd2);
        tick();
        chk("gap_c2", {62'd0, d_gnt_out, eng_req_out}, 64'd0);
        tick();
        chk("gap_rise", {62'd0, d_gnt_out, eng_req_out}, 64'd3);
        drain(50);

        // 6: asynchronous reset mid-BUSY_D, no stale completion afterwards
        eng_lat = 20;
        set_d(1'b0, 3'b100, 32'h2000, 32'h0);
        tick();
        chk("rst_pre_gnt", {63'd0, d_gnt_out}, 64'd1);
        tick();
        chk("rst_pre_busy", {63'd0, eng_req_out}, 64'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("rst_ctl", {55'd0, d_gnt_out, d_done_out, i_gnt_out, i_done_out, eng_req_out,
                        eng_wr_out, eng_width_out}, 64'd0);
        chk("rst_rdata", {d_rdata_out, i_rdata_out}, 64'd0);
        chk("rst_eng", {eng_addr_out, eng_wdata_out}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_in);
        rst_in  = 1'b0;
        eng_lat = 3;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (d_done_out || i_done_out || eng_req_out) cnt++;
        end
        chk("rst_no_stale", cnt, 64'd0);

        chk("sb_empty", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
